// File: rtl/fpcvt_pkg.sv
// Shared types, constants and elaboration helpers for the pipelined int-to-float converter.
package fpcvt_pkg;

  // Per-stage handshake record: stage holds a word / stage can take a word this cycle.
  typedef struct packed {
    logic valid;
    logic ready;
  } stage_hs_t;

  // All-ones saturation patterns; truncate to the exponent/mantissa width at the point of use.
  localparam logic [31:0] E_MAX = '1;
  localparam logic [31:0] F_SAT = '1;

  // The integer must exactly cover the mantissa plus the full exponent range.
  function automatic bit widths_ok(int unsigned d_w, int unsigned e_w, int unsigned f_w);
    return d_w == f_w + (32'd1 << e_w);
  endfunction

endpackage

// File: rtl/fpcvt_if.sv
// Valid/ready bundle between a sample source, the converter and the float consumer.
interface fpcvt_if #(
  parameter int unsigned D_W = 13,
  parameter int unsigned E_W = 3,
  parameter int unsigned F_W = 5
);

  logic           in_valid;
  logic           in_ready;
  logic [D_W-1:0] d;
  logic           out_valid;
  logic           out_ready;
  logic           s;
  logic [E_W-1:0] e;
  logic [F_W-1:0] f;
  logic           ovf;

  // Source/consumer side.
  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, s, e, f, ovf
  );

  // Converter side.
  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, s, e, f, ovf
  );

endinterface

// File: rtl/fpcvt_lod.sv
// Combinational leading-one detector: index of the highest set bit, plus an all-zero flag.
module fpcvt_lod #(
  parameter int unsigned W = 13
) (
  input  logic [W-1:0]         mag_i,
  output logic [$clog2(W)-1:0] pos_o,
  output logic                 zero_o
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    pos_o  = '0;
    zero_o = (mag_i == '0);
    for (int unsigned i = 0; i < W; i++) begin
      if (mag_i[i]) begin
        pos_o = ($clog2(W))'(i);
      end
    end
  end

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage two's-complement integer to sign/exponent/mantissa float converter with
// valid/ready flow control on every stage.
// Build option: define FPCVT_RNE_EN for round-to-nearest-even; otherwise round-half-up.
module fpcvt_pipe
  import fpcvt_pkg::*;
#(
  parameter int unsigned D_W = 13,
  parameter int unsigned E_W = 3,
  parameter int unsigned F_W = 5
) (
  input  logic   clk,
  input  logic   rst,
  fpcvt_if.slave bus_io
);

  localparam int unsigned      PW     = $clog2(D_W);
  localparam logic [PW-1:0]    FwPos  = PW'(F_W);
  localparam logic [E_W-1:0]   EMaxW  = E_W'(E_MAX);
  localparam logic [F_W-1:0]   FSatW  = F_W'(F_SAT);
  localparam logic [F_W-1:0]   FHalf  = {1'b1, {(F_W-1){1'b0}}};

  if (!widths_ok(D_W, E_W, F_W)) begin : g_width_check
    $error("fpcvt_pipe: D_W must equal F_W + 2**E_W");
  end

  stage_hs_t hs1, hs2, hs3;

  // Stage 1 (ABS) state
  logic           v1_q;
  logic           s1_q;
  logic [D_W-1:0] mag1_q;

  // Stage 2 (NORM) state
  logic           v2_q;
  logic           s2_q;
  logic [E_W-1:0] e2_q;
  logic [F_W-1:0] f2_q;
  logic           rnd2_q;
  logic           stk2_q;
  logic           sat2_q;

  // Stage 3 (ROUND) state, drives the outputs directly
  logic           v3_q;
  logic           s3_q;
  logic [E_W-1:0] e3_q;
  logic [F_W-1:0] f3_q;
  logic           ovf3_q;

  // Ready ripples back from the consumer; an empty stage always accepts.
  always_comb begin
    hs3.valid = v3_q;
    hs3.ready = !v3_q || bus_io.out_ready;
    hs2.valid = v2_q;
    hs2.ready = !v2_q || hs3.ready;
    hs1.valid = v1_q;
    hs1.ready = !v1_q || hs2.ready;
  end

  assign bus_io.in_ready  = hs1.ready;
  assign bus_io.out_valid = hs3.valid;
  assign bus_io.s         = s3_q;
  assign bus_io.e         = e3_q;
  assign bus_io.f         = f3_q;
  assign bus_io.ovf       = ovf3_q;

  // Stage 1: capture sign and magnitude of the incoming word.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      s1_q   <= 1'b0;
      mag1_q <= '0;
    end else if (hs1.ready) begin
      v1_q <= bus_io.in_valid;
      if (bus_io.in_valid) begin
        s1_q   <= bus_io.d[D_W-1];
        mag1_q <= bus_io.d[D_W-1] ? -bus_io.d : bus_io.d;
      end
    end
  end

  logic [PW-1:0]  lod_pos;
  logic           lod_zero;
  logic [PW-1:0]  sh_amt;
  logic [D_W-1:0] stk_mask;
  logic [E_W-1:0] e2_d;
  logic [F_W-1:0] f2_d;
  logic           rnd2_d;
  logic           stk2_d;
  logic           sat2_d;

  fpcvt_lod #(
    .W (D_W)
  ) u_lod (
    .mag_i  (mag1_q),
    .pos_o  (lod_pos),
    .zero_o (lod_zero)
  );

  // Stage 2 next-state: align the leading one to the mantissa MSB, keep round and sticky bits.
  always_comb begin
    sh_amt   = '0;
    stk_mask = '0;
    e2_d     = '0;
    f2_d     = mag1_q[F_W-1:0];
    rnd2_d   = 1'b0;
    stk2_d   = 1'b0;
    // Only -2^(D_W-1) reaches the top bit; its exponent would not fit.
    sat2_d   = mag1_q[D_W-1];
    if (!lod_zero && lod_pos >= FwPos) begin
      sh_amt           = lod_pos - FwPos;
      {f2_d, rnd2_d}   = mag1_q[sh_amt +: F_W+1];
      stk_mask         = (D_W'(1) << sh_amt) - D_W'(1);
      stk2_d           = |(mag1_q & stk_mask);
      e2_d             = E_W'(sh_amt) + E_W'(1);
    end
  end

  // Stage 2: register the normalised fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      s2_q   <= 1'b0;
      e2_q   <= '0;
      f2_q   <= '0;
      rnd2_q <= 1'b0;
      stk2_q <= 1'b0;
      sat2_q <= 1'b0;
    end else if (hs2.ready) begin
      v2_q <= hs1.valid;
      if (hs1.valid) begin
        s2_q   <= s1_q;
        e2_q   <= e2_d;
        f2_q   <= f2_d;
        rnd2_q <= rnd2_d;
        stk2_q <= stk2_d;
        sat2_q <= sat2_d;
      end
    end
  end

  logic           up;
  logic [F_W:0]   fsum;
  logic [E_W-1:0] e3_d;
  logic [F_W-1:0] f3_d;
  logic           ovf3_d;

`ifndef FPCVT_RNE_EN
  logic unused_stk;
  assign unused_stk = stk2_q;
`endif

  // Stage 3 next-state: round, renormalise on mantissa carry, saturate on exponent overflow.
  always_comb begin
`ifdef FPCVT_RNE_EN
    up = rnd2_q && (stk2_q || f2_q[0]);
`else
    up = rnd2_q;
`endif
    fsum   = {1'b0, f2_q} + {{F_W{1'b0}}, up};
    e3_d   = e2_q;
    f3_d   = fsum[F_W-1:0];
    ovf3_d = 1'b0;
    if (sat2_q || (fsum[F_W] && e2_q == EMaxW)) begin
      e3_d   = EMaxW;
      f3_d   = FSatW;
      ovf3_d = 1'b1;
    end else if (fsum[F_W]) begin
      e3_d = e2_q + E_W'(1);
      f3_d = FHalf;
    end
  end

  // Stage 3: output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q   <= 1'b0;
      s3_q   <= 1'b0;
      e3_q   <= '0;
      f3_q   <= '0;
      ovf3_q <= 1'b0;
    end else if (hs3.ready) begin
      v3_q <= hs2.valid;
      if (hs2.valid) begin
        s3_q   <= s2_q;
        e3_q   <= e3_d;
        f3_q   <= f3_d;
        ovf3_q <= ovf3_d;
      end
    end
  end

endmodule
